lc4_wb_arbiter: RTL and testbench
=================================

Name: lc4_wb_arbiter

Overview:
- Shares the single write port of the 8-entry LC4 register file between two writeback requesters: A (ALU result) and B (load/memory return).
- Round-robin arbitration with valid/ready handshake; one registered write per cycle to the register file (rd, we, data).
- Integrated scoreboard tracks in-flight writes per register and produces a decode-stage stall for RAW hazards; sits between execute/memory return paths and the register file.

Parameters:
- n, 16, data word width (matches register file word size)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- gwe  in  1  global write enable; no state changes when 0
- a_valid  in  1  requester A has a write
- a_rd  in  3  requester A destination register
- a_data  in  n  requester A write data
- a_ready  out  1  A granted this cycle
- b_valid  in  1  requester B has a write
- b_rd  in  3  requester B destination register
- b_data  in  n  requester B write data
- b_ready  out  1  B granted this cycle
- o_rd_we  out  1  to register file write enable
- o_rd  out  3  to register file destination selector
- o_wdata  out  n  to register file write data
- i_alloc_we  in  1  decode issues instruction that writes a register
- i_alloc_rd  in  3  destination of issuing instruction
- o_alloc_ready  out  1  allocation accepted (counter not saturated)
- i_rs, i_rt  in  3 each  decode source selectors
- i_rs_used, i_rt_used  in  1 each  source actually read
- o_stall  out  1  RAW hazard on a used source
- o_pending  out  8  bit k = register k has in-flight writes
- o_err  out  1  sticky: write transferred to register with zero pending count

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high. All state clears immediately on rst assertion, regardless of clk/gwe.
- Reset values: o_rd_we=0, o_rd=0, o_wdata=0, o_err=0, all counters 0, round-robin pointer = A-priority.
- Grant (combinational): with gwe=0, a_ready=b_ready=0. Otherwise, a lone valid requester is granted. Both valid: the pointer owner is granted. ready never depends on ready; valid must be held with stable rd/data until transfer.
- Transfer = valid & ready. On the transfer edge the pointer moves to the other requester if both were valid, else unchanged.
- Output stage: registered, latency 1. Edge with gwe=1 and transfer: o_rd_we=1, o_rd/o_wdata from winner. Edge with gwe=1 and no transfer: o_rd_we=0, o_rd/o_wdata hold. With gwe=0 all outputs hold.
- Scoreboard: 2-bit saturating-guarded counter per register.
  - Increment on gwe & i_alloc_we & o_alloc_ready at index i_alloc_rd.
  - Decrement on gwe & o_rd_we at index o_rd (the edge the register file commits the write).
  - Increment and decrement on the same register in the same cycle: net unchanged.
  - o_alloc_ready = count[i_alloc_rd] != 3 (combinational). Allocation while not ready is ignored.
- o_pending[k] = count[k] != 0. o_stall = (i_rs_used & o_pending[i_rs]) | (i_rt_used & o_pending[i_rt]). The stall persists through the cycle o_rd_we is high, because the register file has no bypass. It drops the cycle after commit.
- o_err: set at a transfer edge if count[winner rd] == 0 and no same-cycle allocation to that rd; cleared only by rst.
- Decrement at count 0: clamp at 0.

Decomposition:
- Package lc4_wb_pkg: requester ID constants (REQ_A=0, REQ_B=1), CNT_W=2, CNT_MAX=3, NREGS=8.
- Sub-module lc4_wb_scoreboard: eight counters, inc/dec ports, pending vector, alloc_ready. The arbiter and output register stay in the top.

Test Plan:
- Reset mid-operation: assert rst while o_rd_we=1 and count[3]=2 -> o_rd_we, o_pending, o_err go to 0 immediately without a clock edge.
- Alloc r3, then A writes r3=16'h1234 -> a_ready=1 that cycle; next cycle o_rd_we=1, o_rd=3, o_wdata=16'h1234; o_pending[3]=1 and o_stall=1 (i_rs=3, used) through that cycle; both 0 the following cycle.
- Both valid for 4 cycles (A r1/r2, B r5/r6, all allocated) -> grant order A,B,A,B; o_rd sequence 1,5,2,6.
- gwe=0 with both valid -> a_ready=b_ready=0; outputs and counters frozen; resumes with the pending grant when gwe=1.
- Three allocs to r7 -> o_alloc_ready=0; a fourth alloc is ignored. A B write to r7 in the same cycle as a new alloc -> count stays 3.
- B writes r4 with count[4]=0 -> o_err=1, stays 1 until rst; count[4] remains 0.

Source files
------------

// File: rtl/lc4_wb_pkg.sv
// rtl/lc4_wb_pkg.sv - shared types and constants for the LC4 writeback arbiter
package lc4_wb_pkg;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  localparam int CNT_W = 2;
  localparam int NREGS = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 2'd3;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [2:0]       reg_idx_t;

  function automatic req_id_t other_req(input req_id_t r);
    return (r == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/lc4_wb_arbiter_if.sv
// rtl/lc4_wb_arbiter_if.sv - requester, register-file and decode signals of the writeback arbiter
interface lc4_wb_arbiter_if #(
  parameter int n = 16
);

  logic           a_valid;
  logic [2:0]     a_rd;
  logic [n-1:0]   a_data;
  logic           a_ready;

  logic           b_valid;
  logic [2:0]     b_rd;
  logic [n-1:0]   b_data;
  logic           b_ready;

  logic           o_rd_we;
  logic [2:0]     o_rd;
  logic [n-1:0]   o_wdata;

  logic           i_alloc_we;
  logic [2:0]     i_alloc_rd;
  logic           o_alloc_ready;

  logic [2:0]     i_rs;
  logic [2:0]     i_rt;
  logic           i_rs_used;
  logic           i_rt_used;
  logic           o_stall;
  logic [7:0]     o_pending;
  logic           o_err;

  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    input  i_alloc_we, i_alloc_rd,
    input  i_rs, i_rt, i_rs_used, i_rt_used,
    output a_ready, b_ready,
    output o_rd_we, o_rd, o_wdata,
    output o_alloc_ready, o_stall, o_pending, o_err
  );

  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    output i_alloc_we, i_alloc_rd,
    output i_rs, i_rt, i_rs_used, i_rt_used,
    input  a_ready, b_ready,
    input  o_rd_we, o_rd, o_wdata,
    input  o_alloc_ready, o_stall, o_pending, o_err
  );

endinterface

// File: rtl/lc4_wb_scoreboard.sv
// rtl/lc4_wb_scoreboard.sv - per-register in-flight write counters with pending vector
module lc4_wb_scoreboard
  import lc4_wb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  input  reg_idx_t         inc_idx,
  input  logic             dec_en,
  input  reg_idx_t         dec_idx,
  input  reg_idx_t         query_idx,
  output logic             alloc_ready,
  output logic [NREGS-1:0] pending
);

  logic [NREGS-1:0][CNT_W-1:0] cnt_vec;

  for (genvar k = 0; k < NREGS; k++) begin : g_cnt
    cnt_t cnt_q;
    cnt_t cnt_d;
    logic inc_hit;
    logic dec_hit;

    assign inc_hit = inc_en && (inc_idx == 3'(k));
    assign dec_hit = dec_en && (dec_idx == 3'(k));

    // Simultaneous inc/dec cancel; both directions are guarded at the rails.
    always_comb begin
      cnt_d = cnt_q;
      if (inc_hit && !dec_hit) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else if (dec_hit && !inc_hit) begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign cnt_vec[k] = cnt_q;
    assign pending[k] = (cnt_q != '0);
  end

  assign alloc_ready = (cnt_vec[query_idx] != CNT_MAX);

endmodule

// File: rtl/lc4_wb_arbiter.sv
// rtl/lc4_wb_arbiter.sv - round-robin arbiter for the register-file write port
// with registered write stage and RAW-hazard scoreboard.
module lc4_wb_arbiter
  import lc4_wb_pkg::*;
#(
  parameter int n = 16
)(
  input  logic clk,
  input  logic rst,
  input  logic gwe,
  lc4_wb_arbiter_if.slave bus
);

  req_id_t    ptr_q, ptr_d;
  logic       rd_we_q, rd_we_d;
  reg_idx_t   rd_q, rd_d;
  logic [n-1:0] wdata_q, wdata_d;
  logic       err_q, err_d;

  logic       grant_a, grant_b, xfer, both_valid;
  reg_idx_t   win_rd;
  logic [n-1:0] win_data;
  logic       inc_en, dec_en, alloc_ready;
  logic [NREGS-1:0] pending;

  assign both_valid = bus.a_valid && bus.b_valid;

  // Grant depends only on valids and the pointer, never on any ready.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (gwe) begin
      if (both_valid) begin
        grant_a = (ptr_q == REQ_A);
        grant_b = (ptr_q == REQ_B);
      end else begin
        grant_a = bus.a_valid;
        grant_b = bus.b_valid;
      end
    end
  end

  assign xfer     = grant_a || grant_b;
  assign win_rd   = grant_b ? bus.b_rd   : bus.a_rd;
  assign win_data = grant_b ? bus.b_data : bus.a_data;

  assign inc_en = gwe && bus.i_alloc_we && alloc_ready;
  assign dec_en = gwe && rd_we_q;

  always_comb begin
    ptr_d   = ptr_q;
    rd_we_d = rd_we_q;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    if (gwe) begin
      rd_we_d = xfer;
      if (xfer) begin
        rd_d    = win_rd;
        wdata_d = win_data;
        if (both_valid) ptr_d = other_req(ptr_q);
        // A write nobody allocated for, unless decode allocates it this very cycle.
        if (!pending[win_rd] && !(inc_en && (bus.i_alloc_rd == win_rd)))
          err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= REQ_A;
      rd_we_q <= 1'b0;
      rd_q    <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      rd_we_q <= rd_we_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  lc4_wb_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .inc_en      (inc_en),
    .inc_idx     (bus.i_alloc_rd),
    .dec_en      (dec_en),
    .dec_idx     (rd_q),
    .query_idx   (bus.i_alloc_rd),
    .alloc_ready (alloc_ready),
    .pending     (pending)
  );

  // Counters drop on the commit edge, so the stall covers the o_rd_we cycle.
  assign bus.o_stall = (bus.i_rs_used && pending[bus.i_rs]) ||
                       (bus.i_rt_used && pending[bus.i_rt]);

  assign bus.a_ready       = grant_a;
  assign bus.b_ready       = grant_b;
  assign bus.o_rd_we       = rd_we_q;
  assign bus.o_rd          = rd_q;
  assign bus.o_wdata       = wdata_q;
  assign bus.o_alloc_ready = alloc_ready;
  assign bus.o_pending     = pending;
  assign bus.o_err         = err_q;

endmodule

// File: tb/tb_lc4_wb_arbiter.sv
// tb/tb_lc4_wb_arbiter.sv - scoreboard bench for the LC4 writeback arbiter
module tb_lc4_wb_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic gwe;

  always #5 clk = ~clk;

  lc4_wb_arbiter_if #(.n(16)) bus ();

  lc4_wb_arbiter #(.n(16)) dut (
    .clk (clk),
    .rst (rst),
    .gwe (gwe),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [18:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [2:0] rd);
    bus.i_alloc_we = 1'b1;
    bus.i_alloc_rd = rd;
    step();
    bus.i_alloc_we = 1'b0;
  endtask

  // Monitor: every committed register-file write must match the next expected entry.
  initial begin
    logic [18:0] e;
    forever begin
      @(negedge clk);
      if (!rst && gwe && bus.o_rd_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got rd=%0d data=%0h with nothing expected",
                   bus.o_rd, bus.o_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_commit", {13'd0, bus.o_rd, bus.o_wdata}, {13'd0, e});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    gwe = 1'b1;
    bus.a_valid = 1'b0; bus.a_rd = 3'd0; bus.a_data = 16'h0;
    bus.b_valid = 1'b0; bus.b_rd = 3'd0; bus.b_data = 16'h0;
    bus.i_alloc_we = 1'b0; bus.i_alloc_rd = 3'd0;
    bus.i_rs = 3'd0; bus.i_rt = 3'd0; bus.i_rs_used = 1'b0; bus.i_rt_used = 1'b0;
    #12;
    step();
    rst = 1'b0;
    #1;
    chk("rst_rd_we",   bus.o_rd_we, 0);
    chk("rst_rd",      bus.o_rd, 0);
    chk("rst_wdata",   bus.o_wdata, 0);
    chk("rst_err",     bus.o_err, 0);
    chk("rst_pending", bus.o_pending, 0);
    chk("rst_alloc_ready", bus.o_alloc_ready, 1);
    chk("rst_stall",   bus.o_stall, 0);

    // Single A write with RAW stall on r3.
    step();
    alloc(3'd3);
    bus.a_valid = 1'b1; bus.a_rd = 3'd3; bus.a_data = 16'h1234;
    bus.i_rs = 3'd3; bus.i_rs_used = 1'b1;
    exp_q.push_back({3'd3, 16'h1234});
    #1;
    chk("t2_a_ready", bus.a_ready, 1);
    chk("t2_pend_pre", bus.o_pending[3], 1);
    chk("t2_stall_pre", bus.o_stall, 1);
    step();
    bus.a_valid = 1'b0;
    #1;
    chk("t2_rd_we", bus.o_rd_we, 1);
    chk("t2_rd", bus.o_rd, 3);
    chk("t2_wdata", bus.o_wdata, 16'h1234);
    chk("t2_pend_commit", bus.o_pending[3], 1);
    chk("t2_stall_commit", bus.o_stall, 1);
    step();
    #1;
    chk("t2_pend_after", bus.o_pending[3], 0);
    chk("t2_stall_after", bus.o_stall, 0);
    chk("t2_rd_we_after", bus.o_rd_we, 0);
    bus.i_rs_used = 1'b0;

    // Round-robin with both requesters active.
    alloc(3'd1); alloc(3'd2); alloc(3'd5); alloc(3'd6);
    exp_q.push_back({3'd1, 16'h0101});
    exp_q.push_back({3'd5, 16'h0505});
    exp_q.push_back({3'd2, 16'h0202});
    exp_q.push_back({3'd6, 16'h0606});
    bus.a_valid = 1'b1; bus.a_rd = 3'd1; bus.a_data = 16'h0101;
    bus.b_valid = 1'b1; bus.b_rd = 3'd5; bus.b_data = 16'h0505;
    #1;
    chk("rr1_a", {bus.a_ready, bus.b_ready}, 2'b10);
    step();
    bus.a_rd = 3'd2; bus.a_data = 16'h0202;
    #1;
    chk("rr2_b", {bus.a_ready, bus.b_ready}, 2'b01);
    step();
    bus.b_rd = 3'd6; bus.b_data = 16'h0606;
    #1;
    chk("rr3_a", {bus.a_ready, bus.b_ready}, 2'b10);
    step();
    bus.a_valid = 1'b0;
    #1;
    chk("rr4_b", {bus.a_ready, bus.b_ready}, 2'b01);
    step();
    bus.b_valid = 1'b0;
    step();
    step();
    chk("rr_pend_clear", bus.o_pending, 0);

    // gwe=0 freezes grants, outputs and counters; pointer now favours B.
    alloc(3'd2); alloc(3'd6);
    gwe = 1'b0;
    bus.a_valid = 1'b1; bus.a_rd = 3'd2; bus.a_data = 16'h2222;
    bus.b_valid = 1'b1; bus.b_rd = 3'd6; bus.b_data = 16'h6666;
    bus.i_alloc_we = 1'b1; bus.i_alloc_rd = 3'd0;
    #1;
    chk("gwe0_ready", {bus.a_ready, bus.b_ready}, 2'b00);
    step();
    step();
    chk("gwe0_rd_we", bus.o_rd_we, 0);
    chk("gwe0_pending", bus.o_pending, 8'h44);
    chk("gwe0_hold", {13'd0, bus.o_rd, bus.o_wdata}, {13'd0, 3'd6, 16'h0606});
    bus.i_alloc_we = 1'b0;
    gwe = 1'b1;
    exp_q.push_back({3'd6, 16'h6666});
    exp_q.push_back({3'd2, 16'h2222});
    #1;
    chk("gwe1_b", {bus.a_ready, bus.b_ready}, 2'b01);
    step();
    bus.b_valid = 1'b0;
    #1;
    chk("gwe1_a", {bus.a_ready, bus.b_ready}, 2'b10);
    step();
    bus.a_valid = 1'b0;
    step();
    step();
    chk("gwe_pend_clear", bus.o_pending, 0);

    // Saturation on r7 and alloc ignored while not ready.
    alloc(3'd7); alloc(3'd7); alloc(3'd7);
    bus.i_alloc_rd = 3'd7;
    #1;
    chk("sat_ready", bus.o_alloc_ready, 0);
    bus.i_alloc_we = 1'b1;
    step();
    chk("sat_ready_4th", bus.o_alloc_ready, 0);
    chk("sat_pend_4th", bus.o_pending[7], 1);
    bus.b_valid = 1'b1; bus.b_rd = 3'd7; bus.b_data = 16'h7777;
    exp_q.push_back({3'd7, 16'h7777});
    #1;
    chk("sat_b_ready", bus.b_ready, 1);
    step();
    bus.b_valid = 1'b0;
    bus.i_alloc_we = 1'b0;
    #1;
    chk("sat_stays3", bus.o_alloc_ready, 0);
    step();
    chk("sat_dec", bus.o_alloc_ready, 1);
    exp_q.push_back({3'd7, 16'h7001});
    exp_q.push_back({3'd7, 16'h7002});
    bus.b_valid = 1'b1; bus.b_data = 16'h7001;
    step();
    bus.b_data = 16'h7002;
    step();
    bus.b_valid = 1'b0;
    step();
    step();
    chk("sat_pend_clear", bus.o_pending[7], 0);
    chk("sat_no_err", bus.o_err, 0);

    // Unallocated write raises sticky error; counter clamps at zero.
    bus.b_valid = 1'b1; bus.b_rd = 3'd4; bus.b_data = 16'h4444;
    exp_q.push_back({3'd4, 16'h4444});
    step();
    bus.b_valid = 1'b0;
    #1;
    chk("err_set", bus.o_err, 1);
    step();
    step();
    chk("err_clamp", bus.o_pending, 0);
    chk("err_sticky", bus.o_err, 1);

    // Asynchronous reset in the middle of a commit.
    alloc(3'd3); alloc(3'd3);
    bus.a_valid = 1'b1; bus.a_rd = 3'd3; bus.a_data = 16'h3333;
    step();
    bus.a_valid = 1'b0;
    chk("mid_rd_we_pre", bus.o_rd_we, 1);
    chk("mid_pend_pre", bus.o_pending[3], 1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rd_we", bus.o_rd_we, 0);
    chk("mid_pending", bus.o_pending, 0);
    chk("mid_err", bus.o_err, 0);
    chk("mid_rd", {13'd0, bus.o_rd, bus.o_wdata}, 0);
    #1;
    rst = 1'b0;
    step();
    step();
    chk("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
